// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: blanking constants, active-low digit patterns {g,f,e,d,c,b,a},
// and the slot state type used by the scanner.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low patterns for digits 0..9, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] DIGIT_SEG [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } slot_t;

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational digit-to-segment decoder; values >= 10 decode to blank.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   i_digit   [3:0]  binary digit
//   o_pattern [6:0]  active-low segments {g,f,e,d,c,b,a}
module seg_digit_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_pattern
);

    always_comb begin
        o_pattern = SEG_OFF;
        for (int i = 0; i < 10; i++) begin
            if (i_digit == 4'(i)) begin
                o_pattern = DIGIT_SEG[i];
            end
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed 7-segment scanner with dead-time gap between digit slots.
// Latency: outputs lag scan state by 1 cycle; a load is displayed from the next frame.
// Backpressure: none; load is always accepted, display updates only at frame boundaries.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   data_in [3:0]  binary value to display (0..15)
//   load           single-cycle capture strobe for data_in
//   seg     [6:0]  active-low segments {g,f,e,d,c,b,a}, registered
//   an      [3:0]  active-low anodes, an[0]=units, an[1]=tens, an[3:2] held high
//   frame          one-cycle pulse at each frame boundary, registered
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV   = 100_000,
    parameter int GAP_CYCLES = 2_000,
    parameter int BLANK_LZ   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data_in,
    input  logic       load,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END = CNT_W'(GAP_CYCLES);

    generate
        if (SCAN_DIV < 2 || GAP_CYCLES < 1 || GAP_CYCLES >= SCAN_DIV) begin : g_param_check
            $error("seg_scan_driver: need SCAN_DIV >= 2 and 1 <= GAP_CYCLES < SCAN_DIV");
        end
    endgenerate

    logic [CNT_W-1:0] r_scan_cnt;
    logic             r_digit_sel;   // 0 = units slot, 1 = tens slot
    logic [3:0]       r_value_q;     // most recent load
    logic [3:0]       r_disp_q;      // value frozen for the current frame

    logic             w_wrap;
    logic             w_boundary;
    slot_t            w_slot;
    logic             w_tens;
    logic [3:0]       w_units;
    logic [3:0]       w_digit;
    logic             w_blank;
    logic [6:0]       w_pattern;

    assign w_wrap     = (r_scan_cnt == CNT_MAX);
    assign w_boundary = w_wrap & r_digit_sel;
    assign w_slot     = (r_scan_cnt < GAP_END) ? GAP : SHOW;

    // Value is at most 15, so the tens digit is only ever 0 or 1.
    assign w_tens  = (r_disp_q >= 4'd10);
    assign w_units = w_tens ? (r_disp_q - 4'd10) : r_disp_q;
    assign w_digit = r_digit_sel ? {3'b000, w_tens} : w_units;

    // Leading-zero suppression keeps the whole tens slot dark, not just its segments.
    assign w_blank = r_digit_sel && (BLANK_LZ != 0) && !w_tens;

    seg_digit_decode u_decode (
        .i_digit   (w_digit),
        .o_pattern (w_pattern)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan_cnt  <= '0;
            r_digit_sel <= 1'b0;
            r_value_q   <= 4'd0;
            r_disp_q    <= 4'd0;
            seg         <= SEG_OFF;
            an          <= AN_OFF;
            frame       <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_scan_cnt  <= '0;
                r_digit_sel <= ~r_digit_sel;
            end else begin
                r_scan_cnt  <= r_scan_cnt + 1'b1;
            end

            if (load) begin
                r_value_q <= data_in;
            end

            // Boundary samples the pre-edge value_q, so a coincident load waits a frame.
            if (w_boundary) begin
                r_disp_q <= r_value_q;
            end
            frame <= w_boundary;

            if (w_slot == GAP || w_blank) begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
            end else begin
                an  <= r_digit_sel ? 4'b1101 : 4'b1110;
                seg <= w_pattern;
            end
        end
    end

endmodule
